// File: rtl/text_console.sv
// Terminal-style byte writer in front of the GPU text buffer: cursor tracking, control codes,
// hardware scroll and clear. Define TEXT_CONSOLE_TAB_EN to decode 0x09 as a tab to the next 8-column stop.
module text_console #(
  parameter int          ROWS      = 24,
  parameter int          COLS      = 80,
  parameter int          ADDR_W    = 11,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     char_valid,
  input  logic [7:0]               char_data,
  output logic                     char_ready,
  output logic [ADDR_W-1:0]        buf_addr,
  output logic [7:0]               buf_wdata,
  output logic                     buf_we,
  input  logic [7:0]               buf_rdata,
  output logic [$clog2(ROWS)-1:0]  cursor_row,
  output logic [$clog2(COLS)-1:0]  cursor_col,
  output logic                     busy
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_DST  = ADDR_W'((ROWS-1)*COLS-1);
  localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'((ROWS-1)*COLS);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(ROWS*COLS-1);
  localparam logic [RW-1:0]     ROW_MAX   = RW'(ROWS-1);
  localparam logic [CW-1:0]     COL_MAX   = CW'(COLS-1);

  typedef enum logic [2:0] {IDLE, SCROLL_RD, SCROLL_WR, CLEAR_ROW, CLEAR_ALL} state_t;

  state_t             state;
  logic               pend_wr;
  logic [ADDR_W-1:0]  dst;
  logic [7:0]         wdata_q;
  logic [ADDR_W-1:0]  cur_addr;

  logic [RW-1:0]      nx_row;
  logic [CW-1:0]      nx_col;
  logic               do_wr, adv, to_scroll, to_clear;
  logic [ADDR_W-1:0]  wr_addr;
  logic [7:0]         wr_data;
`ifdef TEXT_CONSOLE_TAB_EN
  logic [CW:0]        tab_col;
`endif

  assign cur_addr = ADDR_W'(cursor_row) * COLS_A + ADDR_W'(cursor_col);
  // Scroll copies the read data straight through; everything else writes the registered byte.
  assign buf_wdata = (state == SCROLL_WR) ? buf_rdata : wdata_q;

  always_comb begin
    nx_row    = cursor_row;
    nx_col    = cursor_col;
    do_wr     = 1'b0;
    adv       = 1'b0;
    to_scroll = 1'b0;
    to_clear  = 1'b0;
    wr_addr   = cur_addr;
    wr_data   = char_data;
`ifdef TEXT_CONSOLE_TAB_EN
    tab_col   = {1'b0, cursor_col[CW-1:3], 3'b000} + (CW+1)'(8);
`endif
    if (char_data >= 8'h20 && char_data <= 8'h7E) begin
      do_wr = 1'b1;
      if (cursor_col == COL_MAX) begin
        nx_col = '0;
        adv    = 1'b1;
      end else begin
        nx_col = cursor_col + CW'(1);
      end
    end else begin
      case (char_data)
        8'h0D: nx_col = '0;
        8'h0A: begin
          nx_col = '0;
          adv    = 1'b1;
        end
        8'h08: if (cursor_col != '0) begin
          nx_col  = cursor_col - CW'(1);
          do_wr   = 1'b1;
          wr_data = FILL_CHAR;
          wr_addr = cur_addr - ADDR_W'(1);
        end
        8'h0C: begin
          nx_row   = '0;
          nx_col   = '0;
          to_clear = 1'b1;
        end
`ifdef TEXT_CONSOLE_TAB_EN
        8'h09: if (tab_col >= (CW+1)'(COLS)) begin
          nx_col = '0;
          adv    = 1'b1;
        end else begin
          nx_col = tab_col[CW-1:0];
        end
`endif
        default: ;
      endcase
    end
    if (adv) begin
      if (cursor_row < ROW_MAX) nx_row = cursor_row + RW'(1);
      else                      to_scroll = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pend_wr    <= 1'b0;
      dst        <= '0;
      wdata_q    <= '0;
      buf_addr   <= '0;
      buf_we     <= 1'b0;
      char_ready <= 1'b0;
      busy       <= 1'b0;
      cursor_row <= '0;
      cursor_col <= '0;
    end else begin
      case (state)
        IDLE: begin
          buf_we     <= 1'b0;
          char_ready <= 1'b1;
          if (char_valid && char_ready) begin
            cursor_row <= nx_row;
            cursor_col <= nx_col;
            if (do_wr) begin
              buf_we   <= 1'b1;
              buf_addr <= wr_addr;
              wdata_q  <= wr_data;
            end
            if (to_clear) begin
              state      <= CLEAR_ALL;
              buf_addr   <= '0;
              wdata_q    <= FILL_CHAR;
              buf_we     <= 1'b1;
              char_ready <= 1'b0;
              busy       <= 1'b1;
            end else if (to_scroll) begin
              state      <= SCROLL_RD;
              dst        <= '0;
              char_ready <= 1'b0;
              busy       <= 1'b1;
              // A printable at the last cell occupies the first scroll cycle with its own write.
              pend_wr    <= do_wr;
              if (!do_wr) buf_addr <= COLS_A;
            end
          end
        end
        SCROLL_RD: begin
          if (pend_wr) begin
            pend_wr  <= 1'b0;
            buf_we   <= 1'b0;
            buf_addr <= dst + COLS_A;
          end else begin
            state    <= SCROLL_WR;
            buf_addr <= dst;
            buf_we   <= 1'b1;
          end
        end
        SCROLL_WR: begin
          dst <= dst + ADDR_W'(1);
          if (dst == LAST_DST) begin
            state    <= CLEAR_ROW;
            buf_addr <= LAST_ROW;
            wdata_q  <= FILL_CHAR;
            buf_we   <= 1'b1;
          end else begin
            state    <= SCROLL_RD;
            buf_addr <= dst + ADDR_W'(1) + COLS_A;
            buf_we   <= 1'b0;
          end
        end
        CLEAR_ROW, CLEAR_ALL: begin
          if (buf_addr == LAST_CELL) begin
            state      <= IDLE;
            buf_we     <= 1'b0;
            char_ready <= 1'b1;
            busy       <= 1'b0;
          end else begin
            buf_addr <= buf_addr + ADDR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: a RAM model answers reads, a scoreboard queue holds expected writes.
module tb_text_console;
  localparam int ROWS = 24;
  localparam int COLS = 80;
  localparam int AW   = 11;
  localparam logic [7:0] FILL = 8'h20;

  logic          CLOCK_50 = 1'b0;
  logic          reset = 1'b0;
  logic          char_valid = 1'b0;
  logic [7:0]    char_data = 8'h00;
  logic          char_ready;
  logic [AW-1:0] buf_addr;
  logic [7:0]    buf_wdata;
  logic          buf_we;
  logic [7:0]    buf_rdata;
  logic [4:0]    cursor_row;
  logic [6:0]    cursor_col;
  logic          busy;

  text_console dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .buf_addr(buf_addr), .buf_wdata(buf_wdata), .buf_we(buf_we),
    .buf_rdata(buf_rdata), .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 7 + 3) ^ (i >> 3));
  endfunction

  logic [7:0] mem [0:2047];
  initial for (int i = 0; i < 2048; i++) mem[i] <= pat(i);
  always @(posedge CLOCK_50) begin
    if (buf_we) mem[buf_addr] <= buf_wdata;
    buf_rdata <= mem[buf_addr];
  end

  int total = 0;
  int bad = 0;
  int wr_seen = 0;
  int mrow = 0;
  int mcol = 0;
  logic [18:0] exp_q[$];
  logic [7:0]  model [0:ROWS*COLS-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic [18:0] e;
    @(negedge CLOCK_50);
    if (buf_we === 1'b1) begin
      wr_seen++;
      chk("write_was_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("write_addr_data", {13'd0, buf_addr, buf_wdata}, {13'd0, e});
      end
    end
  endtask

  task automatic push(input int a, input logic [7:0] d);
    exp_q.push_back({AW'(a), d});
    model[a] = d;
  endtask

  task automatic newline();
    if (mrow < ROWS - 1) mrow++;
    else begin
      for (int i = 0; i < (ROWS - 1) * COLS; i++) push(i, model[i + COLS]);
      for (int i = (ROWS - 1) * COLS; i < ROWS * COLS; i++) push(i, FILL);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      push(mrow * COLS + mcol, b);
      mcol++;
      if (mcol == COLS) begin
        mcol = 0;
        newline();
      end
    end else if (b == 8'h0D) mcol = 0;
    else if (b == 8'h0A) begin
      mcol = 0;
      newline();
    end else if (b == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        push(mrow * COLS + mcol, FILL);
      end
    end else if (b == 8'h0C) begin
      mrow = 0;
      mcol = 0;
      for (int i = 0; i < ROWS * COLS; i++) push(i, FILL);
    end
`ifdef TEXT_CONSOLE_TAB_EN
    else if (b == 8'h09) begin
      mcol = (mcol / 8 + 1) * 8;
      if (mcol >= COLS) begin
        mcol = 0;
        newline();
      end
    end
`endif
  endtask

  task automatic send(input logic [7:0] b);
    int g;
    g = 0;
    while (char_ready !== 1'b1 && g < 6000) begin
      step();
      g++;
    end
    if (g >= 6000) chk("ready_before_send", 32'(char_ready), 32'd1);
    char_valid = 1'b1;
    char_data  = b;
    model_byte(b);
    step();
    char_valid = 1'b0;
  endtask

  task automatic send_n(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) send(b);
  endtask

  task automatic wait_ready(output int low);
    low = 0;
    while (char_ready !== 1'b1 && low < 6000) begin
      low++;
      step();
    end
  endtask

  task automatic chk_cursor(input string tag);
    chk(tag, {20'd0, cursor_row, cursor_col}, {20'd0, 5'(mrow), 7'(mcol)});
  endtask

  initial begin
    int low;
    int w0;
    for (int i = 0; i < ROWS * COLS; i++) model[i] = pat(i);

    step();
    step();
    chk("reset_state", {buf_we, buf_addr, buf_wdata, char_ready, busy, cursor_row, cursor_col},
        32'd0);
    reset = 1'b1;
    chk("ready_at_release", 32'(char_ready), 32'd0);
    step();
    chk("ready_after_release", 32'(char_ready), 32'd1);

    // back-to-back 'A','B' with valid held high
    char_valid = 1'b1;
    char_data  = 8'h41;
    model_byte(8'h41);
    step();
    chk("ready_during_burst", 32'(char_ready), 32'd1);
    char_data = 8'h42;
    model_byte(8'h42);
    step();
    chk("ready_after_burst", 32'(char_ready), 32'd1);
    char_valid = 1'b0;
    chk("cursor_after_ab", {20'd0, cursor_row, cursor_col}, {20'd0, 5'd0, 7'd2});

    // wrap at the right edge without scroll
    send_n(8'h78, 77);
    chk("col_before_wrap", 32'(cursor_col), 32'd79);
    send(8'h5A);
    chk("cursor_after_wrap", {20'd0, cursor_row, cursor_col}, {20'd0, 5'd1, 7'd0});
    chk("busy_no_scroll", 32'(busy), 32'd0);

    // LF on the last row scrolls
    send_n(8'h0A, 22);
    send_n(8'h79, 5);
    chk_cursor("cursor_23_5");
    send(8'h0A);
    chk("busy_in_scroll", 32'(busy), 32'd1);
    wait_ready(low);
    chk("scroll_cycles", 32'(low), 32'd3760);
    chk("cursor_after_scroll", {20'd0, cursor_row, cursor_col}, {20'd0, 5'd23, 7'd0});
    chk("busy_after_scroll", 32'(busy), 32'd0);
    chk("scroll_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("row0_from_old_row1", 32'(mem[0]), 32'(model[0]));
    chk("row23_filled", 32'(mem[(ROWS-1)*COLS + 5]), 32'(FILL));

    // full clear
    send(8'h0C);
    wait_ready(low);
    chk("clear_cycles", 32'(low), 32'd1920);
    chk("cursor_after_clear", {20'd0, cursor_row, cursor_col}, 32'd0);
    chk("clear_queue_drained", 32'(exp_q.size()), 32'd0);

    // backspace at col 0 and mid-row
    send_n(8'h0A, 3);
    w0 = wr_seen;
    send(8'h08);
    step();
    chk("bs_col0_no_write", 32'(wr_seen), 32'(w0));
    chk("cursor_bs_col0", {20'd0, cursor_row, cursor_col}, {20'd0, 5'd3, 7'd0});
    send_n(8'h7A, 4);
    send(8'h08);
    chk("cursor_bs", {20'd0, cursor_row, cursor_col}, {20'd0, 5'd3, 7'd3});
    chk("bs_queue_drained", 32'(exp_q.size()), 32'd0);

    // reset in the middle of a clear
    send(8'h0C);
    for (int i = 0; i < 499; i++) step();
    reset = 1'b0;
    #1;
    chk("mid_clear_reset", {27'd0, buf_we, busy, char_ready, 2'b00},  32'd0);
    chk("mid_clear_cursor", {20'd0, cursor_row, cursor_col}, 32'd0);
    exp_q.delete();
    mrow = 0;
    mcol = 0;
    step();
    step();
    reset = 1'b1;
    chk("ready_low_at_rerelease", 32'(char_ready), 32'd0);
    step();
    chk("ready_after_rerelease", 32'(char_ready), 32'd1);

    // tab handling (model follows the macro)
    send_n(8'h71, 3);
    send(8'h09);
    chk_cursor("cursor_tab_0_3");
    send_n(8'h77, 77 - mcol);
    chk("col_before_tab", 32'(cursor_col), 32'd77);
    send(8'h09);
    chk_cursor("cursor_tab_0_77");
    step();
    chk("final_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
